// File: rtl/profir_bank_if.sv
// Sample/coefficient/result bundle for the FIR bank.
// Latency: none, signal grouping only.
// Backpressure: none; the bank flags dropped samples on overrun.
interface profir_bank_if #(
   parameter int NCH   = 8,
   parameter int NTAPS = 64,
   parameter int DW    = 16,
   parameter int CW    = 36
);
   logic signed [DW-1:0]        datain;
   logic                        din_enable;
   logic [$clog2(NTAPS)-1:0]    coeffaddress;
   logic [NCH*CW-1:0]           coeffs;
   logic [NCH*DW-1:0]           dataout;
   logic                        dout_valid;
   logic                        busy;
   logic                        overrun;

   // master: sample source plus coefficient memories; slave: the filter bank
   modport master (
      output datain, din_enable, coeffs,
      input  coeffaddress, dataout, dout_valid, busy, overrun
   );
   modport slave (
      input  datain, din_enable, coeffs,
      output coeffaddress, dataout, dout_valid, busy, overrun
   );
endinterface

// File: rtl/profir_bank.sv
// NCH-channel FIR bank sharing one sample stream; taps are MAC'd serially over a common coeff address.
// Latency: dout_valid NTAPS+3 cycles after an accepted sample. FB_SATURATE_EN clamps results, else they wrap.
// Backpressure: none; a sample arriving while busy is dropped and overrun pulses the next cycle.
module profir_bank #(
   parameter int NCH    = 8,
   parameter int NTAPS  = 64,
   parameter int DW     = 16,
   parameter int CW     = 36,
   parameter int OSHIFT = 34
) (
   input  logic         clock,
   input  logic         reset,
   profir_bank_if.slave bus
);
   localparam int AW   = $clog2(NTAPS);
   localparam int PW   = DW + CW;
   localparam int ACCW = PW + AW;
   localparam logic [AW-1:0]        LAST_TAP = AW'(NTAPS - 1);
   localparam logic signed [ACCW:0] RND_HALF = (ACCW+1)'(1) << (OSHIFT - 1);
`ifdef FB_SATURATE_EN
   localparam logic signed [ACCW:0] SAT_MAX = $signed({{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}});
   localparam logic signed [ACCW:0] SAT_MIN = $signed({{(ACCW-DW+2){1'b1}}, {(DW-1){1'b0}}});
`endif

   typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

   state_t                 state_q;
   logic [AW-1:0]          wp_q;
   logic [AW-1:0]          tap_q;
   logic signed [DW-1:0]   buf_q [NTAPS];
   logic signed [DW-1:0]   x_q;
   logic                   rd_vld_q;
   logic signed [ACCW-1:0] acc_q [NCH];
   logic [NCH*DW-1:0]      dout_q;
   logic                   dout_vld_q;
   logic                   busy_q;
   logic                   ovr_q;

   logic                   accept;
   logic [AW-1:0]          rd_idx;
   logic signed [PW-1:0]   prod [NCH];
   logic [NCH*DW-1:0]      dout_d;

   assign accept = bus.din_enable && (state_q == IDLE);
   // newest sample sits at wp_q-1; x_q lags one cycle to line up with the coeff read
   assign rd_idx = wp_q - AW'(1) - tap_q;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         prod[k] = x_q * $signed(bus.coeffs[k*CW +: CW]);
      end
   end

   always_comb begin : round_reduce
      logic signed [ACCW:0] rnd;
`ifdef FB_SATURATE_EN
      logic signed [ACCW:0] sh;
      sh = '0;
`endif
      rnd    = '0;
      dout_d = '0;
      for (int k = 0; k < NCH; k++) begin
         rnd = $signed({acc_q[k][ACCW-1], acc_q[k]}) + RND_HALF;
`ifdef FB_SATURATE_EN
         sh = rnd >>> OSHIFT;
         if (sh > SAT_MAX)      dout_d[k*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
         else if (sh < SAT_MIN) dout_d[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
         else                   dout_d[k*DW +: DW] = sh[DW-1:0];
`else
         dout_d[k*DW +: DW] = DW'(rnd >>> OSHIFT);
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         wp_q       <= '0;
         tap_q      <= '0;
         x_q        <= '0;
         rd_vld_q   <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
         for (int i = 0; i < NTAPS; i++) buf_q[i] <= '0;
         for (int k = 0; k < NCH; k++)   acc_q[k] <= '0;
      end else begin
         rd_vld_q   <= (state_q == MAC);
         x_q        <= buf_q[rd_idx];
         busy_q     <= accept || (state_q != IDLE);
         ovr_q      <= bus.din_enable && (state_q != IDLE);
         dout_vld_q <= (state_q == OUT);
         if (rd_vld_q) begin
            for (int k = 0; k < NCH; k++) begin
               acc_q[k] <= acc_q[k] + $signed({{AW{prod[k][PW-1]}}, prod[k]});
            end
         end
         case (state_q)
            IDLE: begin
               if (bus.din_enable) begin
                  buf_q[wp_q] <= bus.datain;
                  wp_q        <= wp_q + AW'(1);
                  tap_q       <= '0;
                  for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
                  state_q     <= MAC;
               end
            end
            MAC: begin
               if (tap_q == LAST_TAP) begin
                  tap_q   <= '0;
                  state_q <= FLUSH;
               end else begin
                  tap_q   <= tap_q + AW'(1);
               end
            end
            FLUSH: state_q <= OUT;
            OUT: begin
               dout_q  <= dout_d;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.coeffaddress = tap_q;
   assign bus.dataout      = dout_q;
   assign bus.dout_valid   = dout_vld_q;
   assign bus.busy         = busy_q;
   assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_profir_bank.sv
// Bench for profir_bank: coefficient memories, reference FIR model and result scoreboard.
// Latency: expects each result NTAPS+3 cycles after its accepted sample.
// Backpressure: drives samples at the minimum legal spacing, plus deliberate overruns.
module tb_profir_bank;
   localparam int NCH    = 8;
   localparam int NTAPS  = 64;
   localparam int DW     = 16;
   localparam int CW     = 36;
   localparam int OSHIFT = 34;
   localparam int LAT    = NTAPS + 3;
   localparam logic signed [CW-1:0] ONE  = 36'sh4_0000_0000;
   localparam logic signed [CW-1:0] HALF = 36'sh2_0000_0000;
   localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (DW-1));

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   profir_bank_if #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW)) bus ();

   profir_bank #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OSHIFT(OSHIFT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic signed [CW-1:0] coef [NCH][NTAPS];
   logic [NCH*CW-1:0]    coeffs_r;
   always @(posedge clock) begin
      for (int k = 0; k < NCH; k++) coeffs_r[k*CW +: CW] <= coef[k][bus.coeffaddress];
   end
   assign bus.coeffs = coeffs_r;

   longint cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      longint            due;
      logic [NCH*DW-1:0] dat;
   } res_t;

   res_t   resq [$];
   longint ovq  [$];
   res_t   mon_e;
   int     n_checks = 0;
   int     n_errors = 0;
   longint next_ok  = 0;
   logic signed [DW-1:0] hist [NTAPS];
   int     ref_wp = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] reduce(input longint r);
      logic [DW-1:0] w;
`ifdef FB_SATURATE_EN
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
`endif
      w = r[DW-1:0];
      return w;
   endfunction

   function automatic logic [NCH*DW-1:0] ref_out();
      logic [NCH*DW-1:0] o;
      longint acc;
      longint r;
      o = '0;
      for (int k = 0; k < NCH; k++) begin
         acc = 0;
         for (int i = 0; i < NTAPS; i++)
            acc += longint'(coef[k][i]) * longint'(hist[(ref_wp - 1 - i + NTAPS) % NTAPS]);
         r = (acc + (longint'(1) <<< (OSHIFT-1))) >>> OSHIFT;
         o[k*DW +: DW] = reduce(r);
      end
      return o;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_cyc(input longint c);
      while (cyc < c) tick();
      @(negedge clock);
   endtask

   task automatic accept_model(input logic signed [DW-1:0] s);
      res_t e;
      hist[ref_wp] = s;
      ref_wp = (ref_wp + 1) % NTAPS;
      e.due = cyc + LAT;
      e.dat = ref_out();
      resq.push_back(e);
      next_ok = cyc + LAT;
   endtask

   task automatic send(input logic signed [DW-1:0] s);
      while (cyc < next_ok) tick();
      bus.datain = s;
      bus.din_enable = 1'b1;
      accept_model(s);
      tick();
      bus.din_enable = 1'b0;
   endtask

   task automatic send_overrun(input logic signed [DW-1:0] s1, input logic signed [DW-1:0] s2);
      while (cyc < next_ok) tick();
      bus.datain = s1;
      bus.din_enable = 1'b1;
      accept_model(s1);
      tick();
      bus.datain = s2;
      ovq.push_back(cyc + 1);
      tick();
      bus.din_enable = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2*LAT && (resq.size() != 0 || ovq.size() != 0); i++) tick();
      tick();
      check(tag, resq.size() + ovq.size(), 0);
   endtask

   task automatic set_coefs(input int mode);
      longint v;
      for (int k = 0; k < NCH; k++)
         for (int i = 0; i < NTAPS; i++) begin
            v = longint'($urandom_range(0, 4194303)) - 2097152;
            case (mode)
               1:       coef[k][i] = ONE;
               2:       coef[k][i] = CW'(v <<< 12);
               default: coef[k][i] = '0;
            endcase
         end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_dataout"},    longint'(bus.dataout != '0), 0);
      check({tag, "_dout_valid"}, bus.dout_valid, 0);
      check({tag, "_busy"},       bus.busy, 0);
      check({tag, "_overrun"},    bus.overrun, 0);
      check({tag, "_coeffaddr"},  bus.coeffaddress, 0);
   endtask

   always @(negedge clock) begin
      if (bus.dout_valid === 1'b1) begin
         if (resq.size() == 0) begin
            check("unexpected_valid", bus.dout_valid, 0);
         end else begin
            mon_e = resq.pop_front();
            check("valid_cycle", cyc, mon_e.due);
            for (int k = 0; k < NCH; k++)
               check($sformatf("ch%0d_data", k), $signed(bus.dataout[k*DW +: DW]),
                     $signed(mon_e.dat[k*DW +: DW]));
         end
      end
      if (bus.overrun === 1'b1) begin
         if (ovq.size() == 0) check("unexpected_overrun", bus.overrun, 0);
         else                 check("overrun_cycle", cyc, ovq.pop_front());
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      longint c;
      bus.datain = '0;
      bus.din_enable = 1'b0;
      for (int i = 0; i < NTAPS; i++) hist[i] = '0;
      set_coefs(0);
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clock);
      check_idle_outputs("reset");

      coef[0][5] = ONE;
      send(16'sd1000);
      repeat (9) send(16'sd0);
      drain("impulse_drain");

      send(16'sd100);
      c = next_ok - LAT;
      wait_cyc(c + 1);  check("busy_after_accept", bus.busy, 1);
                        check("addr_first", bus.coeffaddress, 0);
      wait_cyc(c + 5);  check("addr_step", bus.coeffaddress, 4);
      wait_cyc(c + 64); check("addr_last", bus.coeffaddress, NTAPS - 1);
      wait_cyc(c + 65); check("addr_flush", bus.coeffaddress, 0);
      wait_cyc(c + 67); check("busy_in_valid", bus.busy, 1);
      wait_cyc(c + 68); check("busy_released", bus.busy, 0);
      drain("timing_drain");

      set_coefs(0);
      coef[0][0] = HALF;
      send(16'sd3);
      send(-16'sd3);
      drain("round_drain");

      set_coefs(2);
      repeat (20) send(DW'($urandom));
      drain("random_drain");

      send_overrun(DW'($urandom), DW'($urandom));
      send(DW'($urandom));
      send(DW'($urandom));
      drain("overrun_drain");

      set_coefs(1);
      repeat (NTAPS) send(16'sd32767);
      drain("gain_drain");

      send(16'sd1234);
      c = next_ok - LAT;
      while (cyc < c + 10) tick();
      reset = 1'b1;
      bus.datain = 16'sd777;
      bus.din_enable = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      bus.din_enable = 1'b0;
      resq.delete();
      for (int i = 0; i < NTAPS; i++) hist[i] = '0;
      ref_wp = 0;
      next_ok = cyc;
      @(negedge clock);
      check_idle_outputs("midreset");
      repeat (LAT + 10) tick();

      set_coefs(0);
      coef[0][5] = ONE;
      send(16'sd1000);
      repeat (9) send(16'sd0);
      drain("impulse2_drain");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
